// File: rtl/uart_imem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : uart_imem_loader
//  Description : Boot-time program download controller. Assembles a UART
//                byte stream into 32-bit little-endian words and writes them
//                into instruction memory while holding the CPU in reset.
//                Stream format: len[7:0], len[15:8], then len*4 data bytes
//                (plus one trailing XOR checksum byte when
//                UART_LOADER_CHECKSUM_EN is defined).
//  Ports       : clk, reset           - clock, synchronous active-high reset
//                load_req             - start a download (honoured in RUN only)
//                rx_valid, rx_data    - received byte strobe and value
//                cpu_mem_*            - CPU-side instruction-memory write port
//                mem_*                - arbitrated instruction-memory write port
//                cpu_rst              - reset to the CPU core
//                busy / done / err    - status (done and err are sticky)
//  Options     : `define UART_LOADER_CHECKSUM_EN adds the CSUM state and the
//                trailing checksum byte.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_imem_loader #(
    parameter int ADDR_WIDTH = 14,
    parameter int MAX_WORDS  = 16384
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load_req,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_data,
    input  logic                  cpu_mem_we,
    input  logic [ADDR_WIDTH-1:0] cpu_mem_addr,
    input  logic [31:0]           cpu_mem_wdata,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  cpu_rst,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam logic [2:0] C_ST_RUN  = 3'd0;
    localparam logic [2:0] C_ST_HDR0 = 3'd1;
    localparam logic [2:0] C_ST_HDR1 = 3'd2;
    localparam logic [2:0] C_ST_DATA = 3'd3;
    localparam logic [2:0] C_ST_FIN  = 3'd4;
`ifdef UART_LOADER_CHECKSUM_EN
    localparam logic [2:0] C_ST_CSUM = 3'd5;
`endif

    localparam logic [31:0]           C_MAX_WORDS = 32'(MAX_WORDS);
    localparam logic [ADDR_WIDTH-1:0] C_ADDR_ONE  = ADDR_WIDTH'(1);

    logic [2:0]            state_q,    state_d;
    logic [15:0]           len_q,      len_d;
    logic [ADDR_WIDTH-1:0] word_idx_q, word_idx_d;
    logic [1:0]            byte_idx_q, byte_idx_d;
    logic [23:0]           buf_q,      buf_d;      // lanes 0..2 of the word in progress
    logic [ADDR_WIDTH-1:0] ld_addr_q,  ld_addr_d;
    logic [31:0]           ld_wdata_q, ld_wdata_d;
    logic                  wr_pend_q,  wr_pend_d;  // loader write pulse this cycle
    logic                  done_q,     done_d;
    logic                  err_q,      err_d;
`ifdef UART_LOADER_CHECKSUM_EN
    logic [7:0]            csum_q,     csum_d;
`endif

    logic [15:0] w_new_len;
    logic        w_last_word;

    assign w_new_len   = {rx_data, len_q[7:0]};
    // Length was validated to be 1..MAX_WORDS before DATA, so len-1 never underflows there.
    assign w_last_word = ({{(32-ADDR_WIDTH){1'b0}}, word_idx_q} == ({16'd0, len_q} - 32'd1));

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= C_ST_RUN;
            len_q      <= '0;
            word_idx_q <= '0;
            byte_idx_q <= '0;
            buf_q      <= '0;
            ld_addr_q  <= '0;
            ld_wdata_q <= '0;
            wr_pend_q  <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
`ifdef UART_LOADER_CHECKSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            word_idx_q <= word_idx_d;
            byte_idx_q <= byte_idx_d;
            buf_q      <= buf_d;
            ld_addr_q  <= ld_addr_d;
            ld_wdata_q <= ld_wdata_d;
            wr_pend_q  <= wr_pend_d;
            done_q     <= done_d;
            err_q      <= err_d;
`ifdef UART_LOADER_CHECKSUM_EN
            csum_q     <= csum_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Next-state and datapath logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        word_idx_d = word_idx_q;
        byte_idx_d = byte_idx_q;
        buf_d      = buf_q;
        ld_addr_d  = ld_addr_q;
        ld_wdata_d = ld_wdata_q;
        wr_pend_d  = 1'b0;
        done_d     = done_q;
        err_d      = err_q;
`ifdef UART_LOADER_CHECKSUM_EN
        csum_d     = csum_q;
`endif
        case (state_q)
            C_ST_RUN: begin
                if (load_req) begin
                    state_d    = C_ST_HDR0;
                    done_d     = 1'b0;
                    err_d      = 1'b0;
                    word_idx_d = '0;
                    byte_idx_d = '0;
`ifdef UART_LOADER_CHECKSUM_EN
                    csum_d     = '0;
`endif
                end
            end
            C_ST_HDR0: begin
                if (rx_valid) begin
                    len_d[7:0] = rx_data;
                    state_d    = C_ST_HDR1;
                end
            end
            C_ST_HDR1: begin
                if (rx_valid) begin
                    len_d[15:8] = rx_data;
                    if (w_new_len == 16'd0) begin
                        state_d = C_ST_FIN;
                    end else if ({16'd0, w_new_len} > C_MAX_WORDS) begin
                        err_d   = 1'b1;
                        state_d = C_ST_FIN;
                    end else begin
                        state_d = C_ST_DATA;
                    end
                end
            end
            C_ST_DATA: begin
                if (rx_valid) begin
                    byte_idx_d = byte_idx_q + 2'd1;
`ifdef UART_LOADER_CHECKSUM_EN
                    csum_d     = csum_q ^ rx_data;
`endif
                    case (byte_idx_q)
                        2'd0: buf_d[7:0]   = rx_data;
                        2'd1: buf_d[15:8]  = rx_data;
                        2'd2: buf_d[23:16] = rx_data;
                        default: begin
                            // Snapshot the full word so a byte arriving during
                            // the write pulse cannot disturb the written data.
                            wr_pend_d  = 1'b1;
                            ld_addr_d  = word_idx_q;
                            ld_wdata_d = {rx_data, buf_q};
                            word_idx_d = word_idx_q + C_ADDR_ONE;
                            if (w_last_word) begin
`ifdef UART_LOADER_CHECKSUM_EN
                                state_d = C_ST_CSUM;
`else
                                state_d = C_ST_FIN;
`endif
                            end
                        end
                    endcase
                end
            end
`ifdef UART_LOADER_CHECKSUM_EN
            C_ST_CSUM: begin
                if (rx_valid) begin
                    if (rx_data != csum_q) begin
                        err_d = 1'b1;
                    end
                    state_d = C_ST_FIN;
                end
            end
`endif
            C_ST_FIN: begin
                done_d  = 1'b1;
                state_d = C_ST_RUN;
            end
            default: begin
                state_d = C_ST_RUN;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs: CPU owns the memory port only in RUN
    // ------------------------------------------------------------------
    always_comb begin
        busy    = (state_q != C_ST_RUN);
        cpu_rst = reset | busy;
        done    = done_q;
        err     = err_q;
        if (busy) begin
            mem_we    = wr_pend_q;
            mem_addr  = ld_addr_q;
            mem_wdata = ld_wdata_q;
        end else begin
            mem_we    = cpu_mem_we;
            mem_addr  = cpu_mem_addr;
            mem_wdata = cpu_mem_wdata;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_imem_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_uart_imem_loader
//  Description : Self-checking bench for uart_imem_loader: table of directed
//                downloads, hand-written corner sequences and randomized
//                downloads compared against a stream-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_imem_loader;

    localparam int AW   = 14;
    localparam int MAXW = 16384;

    typedef struct {
        int          a;
        logic [31:0] d;
        int          c;
    } wr_t;

    typedef struct {
        logic [0:15][7:0] b;
        int               n;
        logic             e_err;
        int               e_nw;
        logic [31:0]      e_w0;
        logic [31:0]      e_w1;
    } vec_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          load_req;
    logic          rx_valid;
    logic [7:0]    rx_data;
    logic          cpu_mem_we;
    logic [AW-1:0] cpu_mem_addr;
    logic [31:0]   cpu_mem_wdata;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          cpu_rst;
    logic          busy;
    logic          done;
    logic          err;

    uart_imem_loader #(.ADDR_WIDTH(AW), .MAX_WORDS(MAXW)) dut (
        .clk           (clk),
        .reset         (reset),
        .load_req      (load_req),
        .rx_valid      (rx_valid),
        .rx_data       (rx_data),
        .cpu_mem_we    (cpu_mem_we),
        .cpu_mem_addr  (cpu_mem_addr),
        .cpu_mem_wdata (cpu_mem_wdata),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .cpu_rst       (cpu_rst),
        .busy          (busy),
        .done          (done),
        .err           (err)
    );

    always #5 clk = ~clk;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    wr_t  obs[$];
    int   byte_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Loader-owned writes are captured mid-cycle; between them the port must hold.
    always @(negedge clk) begin
        if (busy === 1'b1 && mem_we === 1'b1) begin
            obs.push_back('{int'(mem_addr), mem_wdata, cyc});
        end else if (busy === 1'b1 && obs.size() > 0) begin
            chk("hold addr", 32'(mem_addr), 32'(obs[obs.size()-1].a));
            chk("hold data", mem_wdata, obs[obs.size()-1].d);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap, input bit noisy);
        if (noisy) begin
            cpu_mem_we    = 1'($urandom);
            cpu_mem_addr  = AW'($urandom);
            cpu_mem_wdata = $urandom;
            load_req      = 1'($urandom);
        end else begin
            cpu_mem_we = 1'b0;
            load_req   = 1'b0;
        end
        rx_valid = 1'b1;
        rx_data  = b;
        tick();
        byte_cyc.push_back(cyc);
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
        repeat (gap) tick();
    endtask

    // Reference model works on the whole stream: header gives length, every
    // group of four data bytes is one little-endian word written one cycle
    // after its last byte is accepted.
    task automatic run_load(input logic [7:0] s[$], input int gapmax, input string nm, input bit noisy);
        wr_t        exp[$];
        int         len;
        logic       e_err;
        logic [7:0] x;
        int         k;
        obs.delete();
        byte_cyc.delete();
        load_req = 1'b1;
        tick();
        load_req = 1'b0;
        #1;
        chk({nm, " start busy"},    32'(busy),    32'd1);
        chk({nm, " start done"},    32'(done),    32'd0);
        chk({nm, " start cpu_rst"}, 32'(cpu_rst), 32'd1);
        for (int i = 0; i < s.size(); i++) begin
            send_byte(s[i], $urandom_range(0, gapmax), noisy && (i != s.size() - 1));
        end
        cpu_mem_we = 1'b0;
        load_req   = 1'b0;

        len   = int'(s[0]) + 256 * int'(s[1]);
        e_err = (len > MAXW);
        if (!e_err) begin
            for (int w = 0; w < len; w++) begin
                exp.push_back('{w, {s[2+4*w+3], s[2+4*w+2], s[2+4*w+1], s[2+4*w]}, byte_cyc[2+4*w+3]});
            end
        end
`ifdef UART_LOADER_CHECKSUM_EN
        if (!e_err && len > 0) begin
            x = 8'h00;
            for (int i = 2; i < 2 + 4 * len; i++) x = x ^ s[i];
            e_err = (x != s[2 + 4 * len]);
        end
`endif
        k = 0;
        while (busy !== 1'b0 && k < 10) begin
            tick();
            k++;
        end
        chk({nm, " back to RUN"}, 32'(busy),    32'd0);
        chk({nm, " done"},        32'(done),    32'd1);
        chk({nm, " err"},         32'(err),     32'(e_err));
        chk({nm, " cpu_rst"},     32'(cpu_rst), 32'd0);
        chk({nm, " nwrites"},     32'(obs.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < obs.size(); i++) begin
            chk($sformatf("%s w%0d addr", nm, i), 32'(obs[i].a), 32'(exp[i].a));
            chk($sformatf("%s w%0d data", nm, i), obs[i].d,      exp[i].d);
            chk($sformatf("%s w%0d cyc", nm, i),  32'(obs[i].c), 32'(exp[i].c));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    vec_t       vt[5];
    int         nv;
    logic [7:0] s[$];
    logic [7:0] x;
    int         len;

    initial begin
`ifdef UART_LOADER_CHECKSUM_EN
        vt[0] = '{{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h2A, 40'h0},
                  11, 1'b0, 2, 32'h1234_5678, 32'hDEAD_BEEF};
        vt[1] = '{{8'h00, 8'h00, 112'h0}, 2, 1'b0, 0, 32'h0, 32'h0};
        vt[2] = '{{8'h01, 8'h40, 112'h0}, 2, 1'b1, 0, 32'h0, 32'h0};
        vt[3] = '{{8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04, 72'h0},
                  7, 1'b0, 1, 32'h0403_0201, 32'h0};
        vt[4] = '{{8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 72'h0},
                  7, 1'b1, 1, 32'h0403_0201, 32'h0};
        nv = 5;
`else
        vt[0] = '{{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 48'h0},
                  10, 1'b0, 2, 32'h1234_5678, 32'hDEAD_BEEF};
        vt[1] = '{{8'h00, 8'h00, 112'h0}, 2, 1'b0, 0, 32'h0, 32'h0};
        vt[2] = '{{8'h01, 8'h40, 112'h0}, 2, 1'b1, 0, 32'h0, 32'h0};
        vt[3] = '{{8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 80'h0},
                  6, 1'b0, 1, 32'h4433_2211, 32'h0};
        nv = 4;
`endif

        reset = 1'b1; load_req = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        cpu_mem_we = 1'b0; cpu_mem_addr = '0; cpu_mem_wdata = 32'h0;
        #1;
        repeat (2) tick();
        chk("reset cpu_rst", 32'(cpu_rst), 32'd1);
        chk("reset busy",    32'(busy),    32'd0);
        reset = 1'b0;
        #1;
        chk("post-reset cpu_rst", 32'(cpu_rst), 32'd0);
        chk("post-reset done",    32'(done),    32'd0);
        chk("post-reset err",     32'(err),     32'd0);
        chk("post-reset mem_we",  32'(mem_we),  32'd0);

        // Passthrough in RUN.
        cpu_mem_we = 1'b1; cpu_mem_addr = AW'(5); cpu_mem_wdata = 32'h0000_00A5;
        #1;
        chk("pass we",    32'(mem_we),    32'd1);
        chk("pass addr",  32'(mem_addr),  32'd5);
        chk("pass wdata", mem_wdata,      32'h0000_00A5);
        cpu_mem_we = 1'b0;
        tick();

        // Directed table.
        for (int k = 0; k < nv; k++) begin
            s.delete();
            for (int i = 0; i < vt[k].n; i++) s.push_back(vt[k].b[i]);
            run_load(s, 2, $sformatf("vec%0d", k), 1'b0);
            chk($sformatf("vec%0d tbl err", k), 32'(err), 32'(vt[k].e_err));
            chk($sformatf("vec%0d tbl nw", k),  32'(obs.size()), 32'(vt[k].e_nw));
            if (obs.size() > 0) chk($sformatf("vec%0d tbl w0", k), obs[0].d, vt[k].e_w0);
            if (obs.size() > 1) chk($sformatf("vec%0d tbl w1", k), obs[1].d, vt[k].e_w1);
            tick();
        end

        // load_req coinciding with a CPU write: that write goes through, then the
        // loader owns the port and ignores the CPU.
        obs.delete();
        cpu_mem_we = 1'b1; cpu_mem_addr = AW'(7); cpu_mem_wdata = 32'hCAFE_0007; load_req = 1'b1;
        #1;
        chk("req+cpu we",   32'(mem_we),   32'd1);
        chk("req+cpu addr", 32'(mem_addr), 32'd7);
        tick();
        load_req = 1'b0;
        #1;
        chk("load cpu we ignored", 32'(mem_we), 32'd0);
        chk("load busy",           32'(busy),   32'd1);
        send_byte(8'h00, 0, 1'b0);
        send_byte(8'h00, 0, 1'b0);
        tick();
        chk("zero-len busy",   32'(busy),       32'd0);
        chk("zero-len done",   32'(done),       32'd1);
        chk("zero-len writes", 32'(obs.size()), 32'd0);

        // Reset in the middle of a word: no write, everything back to RUN.
        obs.delete();
        load_req = 1'b1; tick(); load_req = 1'b0;
        send_byte(8'h01, 0, 1'b0); send_byte(8'h00, 0, 1'b0);
        send_byte(8'h11, 0, 1'b0); send_byte(8'h22, 0, 1'b0); send_byte(8'h33, 0, 1'b0);
        chk("midload busy", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        chk("midload rst cpu_rst", 32'(cpu_rst), 32'd1);
        tick();
        reset = 1'b0;
        #1;
        chk("midload after busy",    32'(busy),    32'd0);
        chk("midload after cpu_rst", 32'(cpu_rst), 32'd0);
        chk("midload after done",    32'(done),    32'd0);
        chk("midload after err",     32'(err),     32'd0);
        repeat (3) tick();
        chk("midload writes", 32'(obs.size()), 32'd0);
        // The discarded partial word must not leak into the next download.
        s.delete();
        s.push_back(8'h01); s.push_back(8'h00);
        s.push_back(8'hAA); s.push_back(8'hBB); s.push_back(8'hCC); s.push_back(8'hDD);
`ifdef UART_LOADER_CHECKSUM_EN
        s.push_back(8'h00);
`endif
        run_load(s, 0, "after-reset", 1'b0);
        tick();

        // Length exactly MAX_WORDS is accepted (no err, enters DATA).
        load_req = 1'b1; tick(); load_req = 1'b0;
        send_byte(8'h00, 0, 1'b0); send_byte(8'h40, 0, 1'b0);
        chk("max len err",  32'(err),  32'd0);
        chk("max len busy", 32'(busy), 32'd1);
        reset = 1'b1; tick(); reset = 1'b0; #1;
        chk("max len reset busy", 32'(busy), 32'd0);

        // Randomized downloads with CPU/load_req noise and back-to-back bytes.
        for (int it = 0; it < 30; it++) begin
            len = ($urandom_range(0, 7) == 0) ? MAXW + 1 + int'($urandom_range(0, 3000))
                                               : int'($urandom_range(0, 6));
            s.delete();
            s.push_back(8'(len));
            s.push_back(8'(len >> 8));
            if (len <= MAXW) begin
                x = 8'h00;
                for (int i = 0; i < 4 * len; i++) begin
                    s.push_back(8'($urandom));
                    x = x ^ s[s.size() - 1];
                end
`ifdef UART_LOADER_CHECKSUM_EN
                if (len > 0) begin
                    if ($urandom_range(0, 2) == 0) x = x ^ 8'($urandom_range(1, 255));
                    s.push_back(x);
                end
`endif
            end
            // Bytes in RUN are ignored.
            send_byte(8'($urandom), 0, 1'b0);
            chk($sformatf("rnd%0d rx in RUN", it), 32'(busy), 32'd0);
            cpu_mem_we = 1'b1; cpu_mem_addr = AW'($urandom); cpu_mem_wdata = $urandom;
            #1;
            chk($sformatf("rnd%0d pass addr", it), 32'(mem_addr), 32'(cpu_mem_addr));
            chk($sformatf("rnd%0d pass data", it), mem_wdata, cpu_mem_wdata);
            cpu_mem_we = 1'b0;
            run_load(s, 3, $sformatf("rnd%0d", it), 1'b1);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
